change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Returns change to the customer by driving single-coin pulses, one denomination line at a time.
//  Transmit-side counterpart of the vending FSM coin inputs: it emits the same 5/10/25 rupee pulses.
//  Accepts a change amount from the vending controller over a valid/ready handshake.
//  Pays the amount out greedily (25, then 10, then 5), tracks the coins remaining,
//  and flags any amount it cannot pay as short.
// PARAMETERS
//  AMOUNT_W      8   width of changeAmount/remaining, in rupees
//  PULSE_CYCLES  1   cycles each coin line is held high (>=1)
//  GAP_CYCLES    1   cycles with all coin lines low between coins (>=1)
//  INV_W         6   width of each inventory counter
//  INIT_5        20  5-rupee coins loaded at reset/refill
//  INIT_10       20  10-rupee coins loaded at reset/refill
//  INIT_25       10  25-rupee coins loaded at reset/refill
// PORTS
//  clock                in   1         system clock, rising edge
//  reset                in   1         asynchronous, active-high
//  changeValid          in   1         change request valid
//  changeAmount         in   AMOUNT_W  change to pay, in rupees
//  changeReady          out  1         dispenser idle; request accepted on valid&&ready
//  fiveRupeesOut        out  1         5-rupee coin eject pulse
//  tenRupeesOut         out  1         10-rupee coin eject pulse
//  twentyFiveRupeesOut  out  1         25-rupee coin eject pulse
//  changeDone           out  1         one-cycle pulse at end of payout
//  changeShort          out  1         valid with changeDone: remaining != 0
//  remaining            out  AMOUNT_W  rupees still unpaid (registered)
//  refill               in   1         reload inventory to INIT_* (macro only)
//  emptyFlags           out  3         {25,10,5} inventory==0 (macro only)
// BEHAVIOUR
//  Reset values: outputs 0 except changeReady=1; state IDLE; inventory=INIT_*.
//  Reset mid-payout aborts the pulse immediately; unpaid amount is discarded.
//  FSM states: IDLE, SELECT, PULSE, GAP, DONE.
//  - IDLE:   changeReady=1. On changeValid&&changeReady: remaining<=changeAmount, go to SELECT.
//  - SELECT: 1 cycle. Pick the largest coin c with c<=remaining and a nonzero count for c.
//            Coin found: remaining-=c, count c down by 1, go to PULSE.
//            No coin fits: go to DONE. This includes remaining==0 and any remainder <5.
//  - PULSE:  only the chosen line is high, for PULSE_CYCLES cycles; then go to GAP.
//  - GAP:    all lines low for GAP_CYCLES cycles; then go to SELECT.
//  - DONE:   changeDone=1 and changeShort=(remaining!=0) for 1 cycle; then go to IDLE.
//  At most one coin line is high in any cycle. Coin lines are registered outputs.
//  Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles.
//  changeDone rises in the 2nd cycle after acceptance for amount 0.
//  Strictly greedy, no backtracking: 30 with no 5s left pays 25 and reports short 5.
//  changeValid/changeAmount are ignored unless in IDLE. The request is not re-sampled during payout.
//  remaining holds its final value until the next acceptance.
//  Inventory counters never underflow; a coin with count 0 is never chosen.
// CONFIGURATION
//  CHANGE_DISP_INVENTORY_EN defined:
//   - Inventory is tracked as above.
//   - refill is sampled only in IDLE and sets all counts to INIT_*.
//   - If refill and a request come in the same cycle, the request sees the refilled counts.
//  CHANGE_DISP_INVENTORY_EN undefined:
//   - Supply is unlimited; counters are not built.
//   - refill is ignored and emptyFlags=3'b000.
// TESTING
//  1. Amount 40, full inventory -> 25, 10, 5 pulses in that order;
//     each pulse 1 cycle with a 1-cycle gap; changeShort=0, remaining=0.
//  2. Amount 0 -> no coin pulse; changeDone in 2nd cycle after acceptance; changeShort=0.
//  3. Amount 33 -> 25 then 5 pulses; changeDone with changeShort=1, remaining=3.
//  4. Macro on, INIT_5=0, amount 30 -> one 25 pulse, changeShort=1, remaining=5, emptyFlags[0]=1.
//     Macro off, same stimulus -> 25 then 5, changeShort=0.
//  5. Reset during the PULSE of a 25 coin -> coin lines low at once;
//     after release changeReady=1 and inventory=INIT_*.
//  6. Request 15 accepted; changeValid held with amount 50 during payout -> only 10 then 5 paid;
//     the 50 is accepted on returning to IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 25/10/5 rupee payout FSM fed by a valid/ready change request.
// Define CHANGE_DISP_INVENTORY_EN to build coin inventory counters, refill and emptyFlags.
module change_dispenser #(
    parameter int AMOUNT_W     = 8,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int INV_W        = 6,
    parameter int INIT_5       = 20,
    parameter int INIT_10      = 20,
    parameter int INIT_25      = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                changeValid,
    input  logic [AMOUNT_W-1:0] changeAmount,
    output logic                changeReady,
    output logic                fiveRupeesOut,
    output logic                tenRupeesOut,
    output logic                twentyFiveRupeesOut,
    output logic                changeDone,
    output logic                changeShort,
    output logic [AMOUNT_W-1:0] remaining,
    input  logic                refill,
    output logic [2:0]          emptyFlags
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [AMOUNT_W-1:0] C5  = AMOUNT_W'(32'd5);
    localparam logic [AMOUNT_W-1:0] C10 = AMOUNT_W'(32'd10);
    localparam logic [AMOUNT_W-1:0] C25 = AMOUNT_W'(32'd25);

    logic [2:0]          state_q, state_d;
    logic [AMOUNT_W-1:0] rem_q, rem_d, coin_amt_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          coin_q, coin_d, take_s, avail_s;
    logic                ready_q, ready_d, done_q, done_d, short_q, short_d;

    // Greedy pick: the largest coin that fits the remainder and is in stock.
    always_comb begin
        take_s     = 3'b000;
        coin_amt_s = {AMOUNT_W{1'b0}};
        if (state_q != ST_SELECT) begin
            take_s = 3'b000;
        end else if ((rem_q >= C25) && avail_s[2]) begin
            take_s     = 3'b100;
            coin_amt_s = C25;
        end else if ((rem_q >= C10) && avail_s[1]) begin
            take_s     = 3'b010;
            coin_amt_s = C10;
        end else if ((rem_q >= C5) && avail_s[0]) begin
            take_s     = 3'b001;
            coin_amt_s = C5;
        end else begin
            take_s = 3'b000;
        end
    end

    // Payout sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        short_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (changeValid && ready_q) begin
                    rem_d   = changeAmount;
                    ready_d = 1'b0;
                    state_d = ST_SELECT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SELECT: begin
                cnt_d = {CNT_W{1'b0}};
                if (take_s != 3'b000) begin
                    coin_d  = take_s;
                    rem_d   = rem_q - coin_amt_s;
                    state_d = ST_PULSE;
                end else begin
                    done_d  = 1'b1;
                    short_d = (rem_q != {AMOUNT_W{1'b0}});
                    state_d = ST_DONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    coin_d  = 3'b000;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                coin_d  = 3'b000;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= {AMOUNT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            coin_q  <= 3'b000;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end

    assign changeReady         = ready_q;
    assign fiveRupeesOut       = coin_q[0];
    assign tenRupeesOut        = coin_q[1];
    assign twentyFiveRupeesOut = coin_q[2];
    assign changeDone          = done_q;
    assign changeShort         = short_q;
    assign remaining           = rem_q;

`ifdef CHANGE_DISP_INVENTORY_EN
    logic [INV_W-1:0] inv5_q, inv5_d, inv10_q, inv10_d, inv25_q, inv25_d;
    logic [2:0]       empty_q;

    assign avail_s = {inv25_q != {INV_W{1'b0}}, inv10_q != {INV_W{1'b0}}, inv5_q != {INV_W{1'b0}}};

    // Refill only while idle; take_s is nonzero only for an in-stock coin, so no underflow.
    always_comb begin
        if ((state_q == ST_IDLE) && refill) begin
            inv5_d  = INV_W'(INIT_5);
            inv10_d = INV_W'(INIT_10);
            inv25_d = INV_W'(INIT_25);
        end else begin
            inv5_d  = inv5_q  - INV_W'(take_s[0]);
            inv10_d = inv10_q - INV_W'(take_s[1]);
            inv25_d = inv25_q - INV_W'(take_s[2]);
        end
    end

    // Inventory counters and registered empty flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inv5_q  <= INV_W'(INIT_5);
            inv10_q <= INV_W'(INIT_10);
            inv25_q <= INV_W'(INIT_25);
            empty_q <= {INIT_25 == 0, INIT_10 == 0, INIT_5 == 0};
        end else begin
            inv5_q  <= inv5_d;
            inv10_q <= inv10_d;
            inv25_q <= inv25_d;
            empty_q <= {inv25_d == {INV_W{1'b0}}, inv10_d == {INV_W{1'b0}}, inv5_d == {INV_W{1'b0}}};
        end
    end

    assign emptyFlags = empty_q;
`else
    logic        unused_refill_s;
    logic [31:0] unused_params_s;
    assign unused_refill_s = refill;
    assign unused_params_s = 32'(INV_W + INIT_5 + INIT_10 + INIT_25);
    assign avail_s         = 3'b111;
    assign emptyFlags      = 3'b000;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues expected coins/remainders.
module tb_change_dispenser;
    localparam int AW  = 8;
    localparam int PC  = 1;
    localparam int GC  = 1;
    localparam int I10 = 20;
    localparam int I25 = 10;
`ifdef CHANGE_DISP_INVENTORY_EN
    localparam int I5      = 0;
    localparam bit LIMITED = 1'b1;
`else
    localparam int I5      = 20;
    localparam bit LIMITED = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, changeValid, refill;
    logic [AW-1:0] changeAmount;
    logic          changeReady, fiveRupeesOut, tenRupeesOut, twentyFiveRupeesOut;
    logic          changeDone, changeShort;
    logic [AW-1:0] remaining;
    logic [2:0]    emptyFlags;

    change_dispenser #(
        .AMOUNT_W(AW), .PULSE_CYCLES(PC), .GAP_CYCLES(GC), .INV_W(6),
        .INIT_5(I5), .INIT_10(I10), .INIT_25(I25)
    ) dut (
        .clock(clock), .reset(reset), .changeValid(changeValid), .changeAmount(changeAmount),
        .changeReady(changeReady), .fiveRupeesOut(fiveRupeesOut), .tenRupeesOut(tenRupeesOut),
        .twentyFiveRupeesOut(twentyFiveRupeesOut), .changeDone(changeDone),
        .changeShort(changeShort), .remaining(remaining), .refill(refill), .emptyFlags(emptyFlags)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int inv5, inv10, inv25;
    int exp_coin[$];
    int exp_rem[$];
    int obs_coin[$];
    int obs_rem, obs_short, obs_cycle, obs_high, obs_multi;
    bit obs_done;

    task automatic model_reset();
        inv5  = I5;
        inv10 = I10;
        inv25 = I25;
    endtask

    function automatic logic [2:0] model_empty();
        if (LIMITED) return {inv25 == 0, inv10 == 0, inv5 == 0};
        else return 3'b000;
    endfunction

    task automatic model_push(input int amount);
        int rem = amount;
        while (1'b1) begin
            if (rem >= 25 && (!LIMITED || inv25 > 0)) begin
                exp_coin.push_back(25); rem -= 25; inv25--;
            end else if (rem >= 10 && (!LIMITED || inv10 > 0)) begin
                exp_coin.push_back(10); rem -= 10; inv10--;
            end else if (rem >= 5 && (!LIMITED || inv5 > 0)) begin
                exp_coin.push_back(5); rem -= 5; inv5--;
            end else begin
                break;
            end
        end
        exp_rem.push_back(rem);
    endtask

    task automatic accept(input int amount, input bit hold);
        int waited = 0;
        @(negedge clock);
        changeValid  = 1'b1;
        changeAmount = AW'(amount);
        while (!changeReady && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        total++;
        if (changeReady !== 1'b1) begin
            bad++; $display("FAIL accept_ready got=%b exp=1", changeReady);
        end
        @(posedge clock);
        #1;
        if (!hold) changeValid = 1'b0;
    endtask

    // Observer: cycle 1 is the first cycle after the acceptance edge.
    task automatic collect(input int budget);
        logic [2:0] prev = 3'b000;
        logic [2:0] cur;
        obs_done = 1'b0; obs_high = 0; obs_multi = 0;
        for (int cyc = 1; cyc <= budget && !obs_done; cyc++) begin
            @(negedge clock);
            cur = {twentyFiveRupeesOut, tenRupeesOut, fiveRupeesOut};
            if ($countones(cur) > 1) obs_multi++;
            if (cur != 3'b000) obs_high++;
            if (cur != 3'b000 && prev == 3'b000) obs_coin.push_back(cur[2] ? 25 : (cur[1] ? 10 : 5));
            prev = cur;
            if (changeDone) begin
                obs_done = 1'b1; obs_cycle = cyc; obs_rem = int'(remaining); obs_short = int'(changeShort);
            end
        end
    endtask

    task automatic test_reset_state();
        #12;
        total++;
        if ({changeReady, fiveRupeesOut, tenRupeesOut, twentyFiveRupeesOut, changeDone, changeShort} !== 6'b100000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=100000",
                {changeReady, fiveRupeesOut, tenRupeesOut, twentyFiveRupeesOut, changeDone, changeShort});
        end
        total++;
        if (remaining !== {AW{1'b0}} || emptyFlags !== model_empty()) begin
            bad++; $display("FAIL reset_rem_empty got=%0d/%b exp=0/%b", remaining, emptyFlags, model_empty());
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_payout(input string name, input int amount);
        int ncoins, ec, oc, er;
        model_push(amount);
        ncoins = exp_coin.size();
        accept(amount, 1'b0);
        collect(100);
        total++;
        if (!obs_done) begin bad++; $display("FAIL %s_done got=timeout exp=done", name); end
        while (exp_coin.size() > 0) begin
            ec = exp_coin.pop_front();
            oc = (obs_coin.size() > 0) ? obs_coin.pop_front() : 0;
            total++;
            if (oc !== ec) begin bad++; $display("FAIL %s_coin got=%0d exp=%0d", name, oc, ec); end
        end
        total++;
        if (obs_coin.size() != 0) begin bad++; $display("FAIL %s_extra_coins got=%0d exp=0", name, obs_coin.size()); end
        obs_coin.delete();
        er = exp_rem.pop_front();
        total++;
        if (obs_rem !== er || obs_short !== int'(er != 0)) begin
            bad++; $display("FAIL %s_result got=rem%0d/short%0d exp=rem%0d/short%0d", name, obs_rem, obs_short, er, int'(er != 0));
        end
        total++;
        if (obs_cycle !== 2 + ncoins * (1 + PC + GC)) begin
            bad++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, obs_cycle, 2 + ncoins * (1 + PC + GC));
        end
        total++;
        if (obs_high !== ncoins * PC || obs_multi !== 0) begin
            bad++; $display("FAIL %s_pulses got=high%0d/multi%0d exp=high%0d/multi0", name, obs_high, obs_multi, ncoins * PC);
        end
        total++;
        if (emptyFlags !== model_empty()) begin
            bad++; $display("FAIL %s_empty got=%b exp=%b", name, emptyFlags, model_empty());
        end
        @(negedge clock);
        total++;
        if (int'(remaining) !== er || changeReady !== 1'b1 || changeDone !== 1'b0) begin
            bad++; $display("FAIL %s_hold got=rem%0d/rdy%b/done%b exp=rem%0d/rdy1/done0", name, remaining, changeReady, changeDone, er);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n = 0;
        accept(25, 1'b0);
        while (!twentyFiveRupeesOut && n < 20) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (twentyFiveRupeesOut !== 1'b1) begin bad++; $display("FAIL rst_pulse_seen got=0 exp=1"); end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({fiveRupeesOut, tenRupeesOut, twentyFiveRupeesOut, changeReady} !== 4'b0001) begin
            bad++; $display("FAIL rst_async got=%b exp=0001", {fiveRupeesOut, tenRupeesOut, twentyFiveRupeesOut, changeReady});
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        total++;
        if (changeReady !== 1'b1 || remaining !== {AW{1'b0}} || changeDone !== 1'b0 || emptyFlags !== model_empty()) begin
            bad++; $display("FAIL rst_release got=rdy%b/rem%0d/done%b/empty%b exp=rdy1/rem0/done0/empty%b",
                changeReady, remaining, changeDone, emptyFlags, model_empty());
        end
    endtask

    task automatic test_back_to_back();
        int ec, oc, er;
        model_push(15);
        accept(15, 1'b1);
        changeAmount = AW'(50);
        collect(100);
        total++;
        if (!obs_done) begin bad++; $display("FAIL b2b_first_done got=timeout exp=done"); end
        while (exp_coin.size() > 0) begin
            ec = exp_coin.pop_front();
            oc = (obs_coin.size() > 0) ? obs_coin.pop_front() : 0;
            total++;
            if (oc !== ec) begin bad++; $display("FAIL b2b_first_coin got=%0d exp=%0d", oc, ec); end
        end
        total++;
        if (obs_coin.size() != 0) begin bad++; $display("FAIL b2b_first_extra got=%0d exp=0", obs_coin.size()); end
        obs_coin.delete();
        er = exp_rem.pop_front();
        total++;
        if (obs_rem !== er) begin bad++; $display("FAIL b2b_first_rem got=%0d exp=%0d", obs_rem, er); end
        @(negedge clock);
        total++;
        if (changeReady !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b exp=1", changeReady); end
        model_push(50);
        @(posedge clock);
        #1 changeValid = 1'b0;
        collect(100);
        total++;
        if (!obs_done) begin bad++; $display("FAIL b2b_second_done got=timeout exp=done"); end
        while (exp_coin.size() > 0) begin
            ec = exp_coin.pop_front();
            oc = (obs_coin.size() > 0) ? obs_coin.pop_front() : 0;
            total++;
            if (oc !== ec) begin bad++; $display("FAIL b2b_second_coin got=%0d exp=%0d", oc, ec); end
        end
        obs_coin.delete();
        er = exp_rem.pop_front();
        total++;
        if (obs_rem !== er) begin bad++; $display("FAIL b2b_second_rem got=%0d exp=%0d", obs_rem, er); end
    endtask

    initial begin
        reset        = 1'b1;
        changeValid  = 1'b0;
        changeAmount = {AW{1'b0}};
        refill       = 1'b0;
        model_reset();
        test_reset_state();
        test_payout("full40", 40);
        test_payout("zero", 0);
        test_payout("short33", 33);
        test_payout("greedy30", 30);
        test_reset_mid_pulse();
        test_payout("after_reset40", 40);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
